// File: rtl/salsa20_8_core.sv
// Iterative Salsa20/8 core: one full round per clock, then feed-forward add.
// Start/done pulse handshake; dout holds until the next completed block.
module salsa20_8_core #(
    parameter int ROUNDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [511:0] din,
    output logic [511:0] dout,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    localparam int CW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [15:0][31:0] x, saved, x_rnd, x_sum;
    logic busy_n, done_n, load, step, fin;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c,
        input logic [31:0] d
    );
        logic [31:0] a1, b1, c1, d1;
        b1 = b ^ rotl(a + d, 7);
        c1 = c ^ rotl(b1 + a, 9);
        d1 = d ^ rotl(c1 + b1, 13);
        a1 = a ^ rotl(d1 + c1, 18);
        return {a1, b1, c1, d1};
    endfunction

    // One column round on even counts, one row round on odd counts.
    always_comb begin
        x_rnd = x;
        if (!cnt[0]) begin
            {x_rnd[0], x_rnd[4], x_rnd[8], x_rnd[12]} = qr(x[0], x[4], x[8], x[12]);
            {x_rnd[5], x_rnd[9], x_rnd[13], x_rnd[1]} = qr(x[5], x[9], x[13], x[1]);
            {x_rnd[10], x_rnd[14], x_rnd[2], x_rnd[6]} = qr(x[10], x[14], x[2], x[6]);
            {x_rnd[15], x_rnd[3], x_rnd[7], x_rnd[11]} = qr(x[15], x[3], x[7], x[11]);
        end else begin
            {x_rnd[0], x_rnd[1], x_rnd[2], x_rnd[3]} = qr(x[0], x[1], x[2], x[3]);
            {x_rnd[5], x_rnd[6], x_rnd[7], x_rnd[4]} = qr(x[5], x[6], x[7], x[4]);
            {x_rnd[10], x_rnd[11], x_rnd[8], x_rnd[9]} = qr(x[10], x[11], x[8], x[9]);
            {x_rnd[15], x_rnd[12], x_rnd[13], x_rnd[14]} = qr(x[15], x[12], x[13], x[14]);
        end
    end

    // Feed-forward: per-word add of the working state and the saved input.
    always_comb begin
        x_sum = '0;
        for (int i = 0; i < 16; i++) begin
            x_sum[i] = x[i] + saved[i];
        end
    end

    // Next-state and handshake decode; done is a single-cycle pulse.
    always_comb begin
        state_n = state;
        busy_n  = busy;
        done_n  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = ROUND;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_n = FINAL;
                end
            end
            FINAL: begin
                fin     = 1'b1;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Working state, saved input, round counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            saved <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            if (load) begin
                x     <= din;
                saved <= din;
                cnt   <= '0;
            end
            if (step) begin
                x   <= x_rnd;
                cnt <= cnt + 1'b1;
            end
            if (fin) begin
                dout <= x_sum;
            end
        end
    end

endmodule

// File: tb/tb_salsa20_8_core.sv
// Directed bench for salsa20_8_core: RFC 7914 vector, latency,
// busy-ignore, mid-operation reset and back-to-back handshake.
module tb_salsa20_8_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [511:0] din;
    logic [511:0] dout;
    logic         busy;
    logic         done;
    logic         done_q = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [511:0] A_STR = 512'h
        7e879a21_4f3ec986_7ca940e6_41718f26_baee555b_8c61c1b5_0df84611_6dcd3b1d_ee24f319_df9b3d85_14121e4b_5ac5aa32_76021d29_09c74829_edebc68d_b8b8c25e;
    localparam logic [511:0] R_STR = 512'h
        a41f859c_6608cc99_3b81cacb_020cef05_044b2181_a2fd337d_fd7b1c63_96682f29_b4393168_e3c9e6bc_fe6bc5b7_a06d96ba_e424cc10_2c91745c_24ad673d_c7618f81;

    logic [511:0] blk_a, res_a;

    salsa20_8_core #(.ROUNDS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .din    (din),
        .dout   (dout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Byte string (first byte in the MSBs) to little-endian packing.
    function automatic logic [511:0] to_blk(input logic [511:0] s);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) begin
            r[8*k +: 8] = s[511 - 8*k -: 8];
        end
        return r;
    endfunction

    task automatic check(
        input string        tag,
        input logic [511:0] got,
        input logic [511:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    // Pulse-width and exclusivity checks on every done cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("busy_and_done", {511'b0, busy}, 512'd0);
            check("done_2cyc", {511'b0, done_q}, 512'd0);
        end
    end

    always @(negedge clk) done_q <= done;

    initial begin
        int n, m, ndone, kd, busy_again, seen_busy;
        blk_a  = to_blk(A_STR);
        res_a  = to_blk(R_STR);
        rst    = 1'b1;
        enable = 1'b0;
        din    = '0;
        tick();
        tick();
        check("rst_busy", {511'b0, busy}, 512'd0);
        check("rst_done", {511'b0, done}, 512'd0);
        check("rst_dout", dout, 512'd0);
        rst = 1'b0;
        tick();

        // Zero block.
        din    = '0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("t1_busy", {511'b0, busy}, 512'd1);
        wait_done(n);
        check("t1_lat", 512'(n), 512'd9);
        check("t1_dout", dout, 512'd0);
        tick();
        check("t1_pulse", {511'b0, done}, 512'd0);
        check("t1_idle", {511'b0, busy}, 512'd0);

        // RFC 7914 Salsa20/8 vector; din scrambled after acceptance.
        din    = blk_a;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        din    = ~blk_a;
        wait_done(n);
        check("t2_lat", 512'(n), 512'd9);
        check("t2_dout", dout, res_a);
        tick();
        check("t2_pulse", {511'b0, done}, 512'd0);
        check("t2_hold", dout, res_a);

        // Enable pulses while busy are ignored.
        din    = blk_a;
        enable = 1'b1;
        tick();
        enable     = 1'b0;
        din        = '0;
        ndone      = 0;
        kd         = -1;
        busy_again = 0;
        for (int k = 1; k <= 20; k++) begin
            enable = (k == 3 || k == 7);
            tick();
            enable = 1'b0;
            if (done) begin
                ndone++;
                kd = k;
            end
            if (k > 9 && busy) busy_again = 1;
        end
        check("t3_ndone", 512'(ndone), 512'd1);
        check("t3_lat", 512'(kd), 512'd9);
        check("t3_dout", dout, res_a);
        check("t3_rebusy", 512'(busy_again), 512'd0);

        // Reset in the middle of an operation.
        din    = blk_a;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", {511'b0, busy}, 512'd0);
        check("t4_dout", dout, 512'd0);
        ndone     = 0;
        seen_busy = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done) ndone++;
            if (busy) seen_busy = 1;
        end
        check("t4_nodone", 512'(ndone), 512'd0);
        check("t4_nobusy", 512'(seen_busy), 512'd0);
        check("t4_dout_idle", dout, 512'd0);
        din    = blk_a;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(n);
        check("t4_lat", 512'(n), 512'd9);
        check("t4_dout2", dout, res_a);
        tick();

        // Back-to-back: enable held high, B applied in the done cycle.
        din    = blk_a;
        enable = 1'b1;
        tick();
        wait_done(n);
        check("t5_lat_a", 512'(n), 512'd9);
        check("t5_dout_a", dout, res_a);
        din = '0;
        tick();
        enable = 1'b0;
        check("t5_busy_b", {511'b0, busy}, 512'd1);
        check("t5_hold_a", dout, res_a);
        wait_done(m);
        check("t5_gap", 512'(m + 1), 512'd10);
        check("t5_dout_b", dout, 512'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
